// File: rtl/seq_ctrl.sv
// seq_ctrl: multi-cycle sequencer for the nRisc datapath.
// Steps each instruction through FETCH, DECODE, EXEC, MEM and WB and drives
// the datapath strobes, ALU/mux selects and memory req/ack handshakes.
// Memory waits are bounded by WAIT_MAX cycles (0 disables the timeout).
//
// Ports:
//   clock_i        system clock, rising edge
//   reset_ni       asynchronous active-low reset
//   start_i        level; leaves IDLE
//   opcode_i[2:0]  opcode from IR, captured in DECODE
//   zero_i         ALU zero flag, used by beq in EXEC
//   imem_req_o / imem_ack_i   instruction memory handshake
//   dmem_req_o / dmem_we_o / dmem_ack_i   data memory handshake
//   ir_load_o, pc_we_o, pc_sel_o[1:0], reg_we_o   datapath strobes/selects
//   alu_op_o[1:0], ula_fonte_o, mem_to_reg_o, move_reg_o, reg_dest_o
//   busy_o, halted_o, error_o  status
//   instr_count_o[15:0]        retired instructions, saturating
module seq_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clock_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [2:0]  opcode_i,
    input  logic        zero_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        ir_load_o,
    output logic        pc_we_o,
    output logic [1:0]  pc_sel_o,
    output logic        reg_we_o,
    output logic [1:0]  alu_op_o,
    output logic        ula_fonte_o,
    output logic        mem_to_reg_o,
    output logic        move_reg_o,
    output logic        reg_dest_o,
    output logic        busy_o,
    output logic        halted_o,
    output logic        error_o,
    output logic [15:0] instr_count_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_MOVE = 3'b001;
    localparam logic [2:0] OP_SLT  = 3'b010;
    localparam logic [2:0] OP_BEQ  = 3'b011;
    localparam logic [2:0] OP_JUMP = 3'b100;
    localparam logic [2:0] OP_SW   = 3'b101;
    localparam logic [2:0] OP_LW   = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Counter value seen in the last allowed wait cycle.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [3:0]  wait_q, wait_d;
    logic [15:0] cnt_q;
    logic        timeout;

    assign timeout = (WAIT_MAX != 0) && (wait_q == WAIT_LAST);

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
            if (pc_we_o && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_count_o = cnt_q;

    // Next state and outputs. The wait counter defaults to zero so it is
    // cleared whenever we are not stalled in FETCH/MEM, which covers every
    // entry into those states. The ack inputs gate ir_load/pc_we in the
    // handshake cycle so each strobe fires exactly once without an extra state.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        wait_d       = '0;
        imem_req_o   = 1'b0;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        ir_load_o    = 1'b0;
        pc_we_o      = 1'b0;
        pc_sel_o     = 2'b00;
        reg_we_o     = 1'b0;
        alu_op_o     = 2'b00;
        ula_fonte_o  = 1'b0;
        mem_to_reg_o = 1'b0;
        move_reg_o   = 1'b0;
        reg_dest_o   = 1'b0;
        halted_o     = 1'b0;
        error_o      = 1'b0;

        case (state_q)
            S_IDLE: if (start_i) state_d = S_FETCH;
            S_FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_load_o = 1'b1;
                    state_d   = S_DECODE;
                end else if (timeout) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                // op_q is not loaded yet, so the branch uses the live opcode.
                op_d    = opcode_i;
                state_d = (opcode_i == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                case (op_q)
                    OP_ADD: begin
                        ula_fonte_o = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_SLT: begin
                        alu_op_o = 2'b10;
                        state_d  = S_WB;
                    end
                    OP_MOVE: state_d = S_WB;
                    OP_BEQ: begin
                        alu_op_o = 2'b01;
                        pc_we_o  = 1'b1;
                        pc_sel_o = zero_i ? 2'b01 : 2'b00;
                        state_d  = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_we_o  = 1'b1;
                        pc_sel_o = 2'b10;
                        state_d  = S_FETCH;
                    end
                    OP_SW, OP_LW: state_d = S_MEM;
                    default: state_d = S_ERR;
                endcase
            end
            S_MEM: begin
                dmem_req_o = 1'b1;
                dmem_we_o  = (op_q == OP_SW);
                if (dmem_ack_i) begin
                    if (op_q == OP_SW) begin
                        pc_we_o = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (timeout) begin
                    state_d = S_ERR;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WB: begin
                reg_we_o = 1'b1;
                pc_we_o  = 1'b1;
                if (op_q == OP_LW)        mem_to_reg_o = 1'b1;
                else if (op_q == OP_MOVE) move_reg_o   = 1'b1;
                else                      reg_dest_o   = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT: halted_o = 1'b1;
            S_ERR:  error_o  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy_o = (state_q != S_IDLE) && (state_q != S_HALT) && (state_q != S_ERR);

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl: add, beq taken/not taken, lw with data wait,
// halt, fetch timeout and ack on the last allowed cycle, reset during MEM, sw.
module tb_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  opcode = 3'b000;
    logic        zero = 1'b0;
    logic        imem_ack = 1'b0;
    logic        dmem_ack = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_load, pc_we, reg_we;
    logic [1:0]  pc_sel, alu_op;
    logic        ula_fonte, mem_to_reg, move_reg, reg_dest, busy, halted, error;
    logic [15:0] cnt;
    logic [16:0] outs;

    int tests = 0;
    int fails = 0;

    localparam logic [2:0] OP_ADD = 3'b000, OP_BEQ = 3'b011, OP_SW = 3'b101,
                           OP_LW = 3'b110, OP_HALT = 3'b111;

    // Bit positions within outs.
    localparam logic [31:0] IREQ = 32'h1 << 16, DREQ = 32'h1 << 15, DWE = 32'h1 << 14,
                            IRL = 32'h1 << 13, PCWE = 32'h1 << 12,
                            PCS_BR = 32'h1 << 10, PCS_J = 32'h2 << 10,
                            RWE = 32'h1 << 9, ALU_SUB = 32'h1 << 7, ALU_SLT = 32'h2 << 7,
                            UF = 32'h1 << 6, M2R = 32'h1 << 5, MV = 32'h1 << 4,
                            RD = 32'h1 << 3, BUSY = 32'h4, HLT = 32'h2, ERRB = 32'h1;

    always #5 clk = ~clk;

    seq_ctrl #(.WAIT_MAX(15)) dut (
        .clock_i(clk), .reset_ni(rst_n), .start_i(start), .opcode_i(opcode),
        .zero_i(zero), .imem_req_o(imem_req), .imem_ack_i(imem_ack),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ack_i(dmem_ack),
        .ir_load_o(ir_load), .pc_we_o(pc_we), .pc_sel_o(pc_sel), .reg_we_o(reg_we),
        .alu_op_o(alu_op), .ula_fonte_o(ula_fonte), .mem_to_reg_o(mem_to_reg),
        .move_reg_o(move_reg), .reg_dest_o(reg_dest), .busy_o(busy),
        .halted_o(halted), .error_o(error), .instr_count_o(cnt)
    );

    assign outs = {imem_req, dmem_req, dmem_we, ir_load, pc_we, pc_sel, reg_we,
                   alu_op, ula_fonte, mem_to_reg, move_reg, reg_dest, busy, halted, error};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Short reset pulse ending well before the next rising edge.
    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1;
        chk("rst_outs", {15'b0, outs}, 32'h0);
        chk("rst_cnt", {16'b0, cnt}, 32'h0);

        // add with start already high at reset release
        start = 1'b1; imem_ack = 1'b1; opcode = OP_ADD;
        @(negedge clk); rst_n = 1'b1;
        cyc(); chk("add_fetch", {15'b0, outs}, IREQ | IRL | BUSY);
        cyc(); chk("add_decode", {15'b0, outs}, BUSY);
        cyc(); chk("add_exec", {15'b0, outs}, UF | BUSY);
        cyc(); chk("add_wb", {15'b0, outs}, RWE | PCWE | RD | BUSY);
        chk("add_cnt_pre", {16'b0, cnt}, 32'd0);
        cyc(); chk("add_cnt", {16'b0, cnt}, 32'd1);
        chk("fetch2", {15'b0, outs}, IREQ | IRL | BUSY);

        // beq taken, then not taken
        start = 1'b0; opcode = OP_BEQ; zero = 1'b1;
        cyc();
        cyc(); chk("beq1_exec", {15'b0, outs}, ALU_SUB | PCWE | PCS_BR | BUSY);
        cyc(); chk("beq1_cnt", {16'b0, cnt}, 32'd2);
        zero = 1'b0;
        cyc();
        cyc(); chk("beq0_exec", {15'b0, outs}, ALU_SUB | PCWE | BUSY);
        zero = 1'b1; #1;
        chk("beq_zero_path", {15'b0, outs}, ALU_SUB | PCWE | PCS_BR | BUSY);
        zero = 1'b0;
        cyc(); chk("beq0_cnt", {16'b0, cnt}, 32'd3);

        // lw with dmem_ack arriving in the 4th MEM cycle
        opcode = OP_LW;
        cyc();
        cyc(); chk("lw_exec", {15'b0, outs}, BUSY);
        for (int i = 0; i < 3; i++) begin
            cyc(); chk("lw_mem_wait", {15'b0, outs}, DREQ | BUSY);
        end
        cyc(); dmem_ack = 1'b1; #1;
        chk("lw_mem_ack", {15'b0, outs}, DREQ | BUSY);
        cyc(); dmem_ack = 1'b0;
        chk("lw_wb", {15'b0, outs}, RWE | PCWE | M2R | BUSY);
        cyc(); chk("lw_cnt", {16'b0, cnt}, 32'd4);
        chk("lw_after", {15'b0, outs}, IREQ | IRL | BUSY);

        // two adds then halt
        opcode = OP_ADD; start = 1'b1;
        pulse_reset();
        repeat (9) cyc();
        chk("halt_pre_cnt", {16'b0, cnt}, 32'd2);
        opcode = OP_HALT;
        cyc(); chk("halt_decode", {15'b0, outs}, BUSY);
        cyc(); chk("halt", {15'b0, outs}, HLT);
        start = 1'b0; cyc(); start = 1'b1; cyc(); start = 1'b0; cyc();
        chk("halt_hold", {15'b0, outs}, HLT);
        chk("halt_cnt", {16'b0, cnt}, 32'd2);

        // fetch timeout: 15 cycles without ack
        imem_ack = 1'b0; start = 1'b1;
        pulse_reset();
        cyc();
        repeat (14) cyc();
        chk("to_c15", {15'b0, outs}, IREQ | BUSY);
        cyc(); chk("to_err", {15'b0, outs}, ERRB);
        cyc(); cyc(); chk("to_err_hold", {15'b0, outs}, ERRB);

        // ack in the 15th cycle wins over the timeout
        opcode = OP_ADD;
        pulse_reset();
        cyc();
        repeat (14) cyc();
        imem_ack = 1'b1; #1;
        chk("late_ack", {15'b0, outs}, IREQ | IRL | BUSY);
        cyc(); chk("late_ack_decode", {15'b0, outs}, BUSY);
        cyc(); cyc(); cyc(); chk("late_ack_cnt", {16'b0, cnt}, 32'd1);

        // sw with ack pending, reset in MEM
        opcode = OP_SW;
        cyc();
        cyc(); chk("sw_exec", {15'b0, outs}, BUSY);
        cyc(); chk("sw_mem", {15'b0, outs}, DREQ | DWE | BUSY);
        #2; rst_n = 1'b0; #1;
        chk("rst_mid_outs", {15'b0, outs}, 32'h0);
        chk("rst_mid_cnt", {16'b0, cnt}, 32'd0);
        start = 1'b0;
        cyc(); chk("rst_held", {15'b0, outs}, 32'h0);
        rst_n = 1'b1;
        cyc(); chk("idle_hold", {15'b0, outs}, 32'h0);

        // sw with immediate acks
        start = 1'b1; dmem_ack = 1'b1;
        cyc(); cyc(); cyc();
        cyc(); chk("sw_mem_ack", {15'b0, outs}, DREQ | DWE | PCWE | BUSY);
        cyc(); chk("sw_cnt", {16'b0, cnt}, 32'd1);
        chk("sw_after", {15'b0, outs}, IREQ | IRL | BUSY);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
